// File: rtl/mips_if_bpu_pkg.sv
// Shared definitions for the IF-stage branch prediction unit: widths,
// FSM state encoding, BHT counter reset value and the saturating-counter step.
package mips_if_bpu_pkg;

    localparam int MIPS_ADDR_WIDTH  = 32;
    localparam int MIPS_RFIDX_WIDTH = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RS = 1'b1
    } bpu_state_t;

    localparam logic [1:0] BHT_CNT_RST = 2'b01;

    // 2-bit saturating counter: taken counts up to 2'b11, not-taken down to 2'b00
    function automatic logic [1:0] satCount(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mips_if_bpu_if.sv
// Bundle between the fetch sequencer / mini-decoder / EX resolution and the BPU.
// master = fetch side driving decode and update fields, slave = the BPU.
interface mips_if_bpu_if
    import mips_if_bpu_pkg::*;
#(
    parameter int ADDR_W  = MIPS_ADDR_WIDTH,
    parameter int RFIDX_W = MIPS_RFIDX_WIDTH
);
    logic               if_vld;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_incr;
    logic               dec_bjp;
    logic               dec_j;
    logic               dec_jal;
    logic               dec_jr;
    logic               dec_jalr;
    logic               dec_bxx;
    logic [ADDR_W-1:0]  dec_j_imm;
    logic [ADDR_W-1:0]  dec_b_imm;
    logic [RFIDX_W-1:0] dec_rs_idx;
    logic [ADDR_W-1:0]  jr_rs_val;
    logic               jr_rs_busy;
    logic               upd_vld;
    logic [ADDR_W-1:0]  upd_pc;
    logic               upd_taken;
    logic               flush;
    logic               prdt_vld;
    logic               prdt_taken;
    logic [ADDR_W-1:0]  prdt_pc;
    logic               bpu_wait;

    modport master (
        output if_vld, if_pc, if_pc_incr,
        output dec_bjp, dec_j, dec_jal, dec_jr, dec_jalr, dec_bxx,
        output dec_j_imm, dec_b_imm, dec_rs_idx,
        output jr_rs_val, jr_rs_busy,
        output upd_vld, upd_pc, upd_taken, flush,
        input  prdt_vld, prdt_taken, prdt_pc, bpu_wait
    );

    modport slave (
        input  if_vld, if_pc, if_pc_incr,
        input  dec_bjp, dec_j, dec_jal, dec_jr, dec_jalr, dec_bxx,
        input  dec_j_imm, dec_b_imm, dec_rs_idx,
        input  jr_rs_val, jr_rs_busy,
        input  upd_vld, upd_pc, upd_taken, flush,
        output prdt_vld, prdt_taken, prdt_pc, bpu_wait
    );

endinterface

// File: rtl/mips_if_bpu_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters with one
// asynchronous read port and one update port written at the clock edge.
module mips_if_bht
    import mips_if_bpu_pkg::*;
#(
    parameter  int BHT_DEPTH = 64,
    localparam int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BHT_IDX_W-1:0] i_rd_idx,
    output logic [1:0]           o_rd_cnt,
    input  logic                 i_upd_vld,
    input  logic [BHT_IDX_W-1:0] i_upd_idx,
    input  logic                 i_upd_taken
);

    logic [1:0] r_cnt [BHT_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_cnt[i] <= BHT_CNT_RST;
            end
        end else if (i_upd_vld) begin
            r_cnt[i_upd_idx] <= satCount(r_cnt[i_upd_idx], i_upd_taken);
        end
    end

    // No bypass: a same-cycle update is only visible after the edge
    assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/mips_if_bpu.sv
// IF-stage branch prediction unit. Define MIPS_BPU_BHT_EN for dynamic BHT
// prediction of Bxx; without it Bxx uses static backward-taken/forward-not-taken.
module mips_if_bpu
    import mips_if_bpu_pkg::*;
#(
    parameter int ADDR_W    = MIPS_ADDR_WIDTH,
    parameter int RFIDX_W   = MIPS_RFIDX_WIDTH,
    parameter int BHT_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_if_bpu_if.slave  bus
);

    localparam int BHT_IDX_W = $clog2(BHT_DEPTH);

    bpu_state_t        r_state;
    bpu_state_t        w_next;
    logic              w_is_jump;
    logic              w_is_jreg;
    logic              w_bxx_taken;
    logic [ADDR_W-1:0] w_b_target;
    logic              w_prdt_vld;
    logic              w_prdt_taken;
    logic [ADDR_W-1:0] w_prdt_pc;
    logic              w_bpu_wait;
    logic              w_unused;

    assign w_is_jump  = bus.dec_j | bus.dec_jal;
    assign w_is_jreg  = bus.dec_jr | bus.dec_jalr;
    assign w_b_target = bus.if_pc_incr + bus.dec_b_imm;

`ifdef MIPS_BPU_BHT_EN
    logic [1:0] w_rd_cnt;

    mips_if_bht #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (bus.if_pc[BHT_IDX_W+1:2]),
        .o_rd_cnt    (w_rd_cnt),
        .i_upd_vld   (bus.upd_vld),
        .i_upd_idx   (bus.upd_pc[BHT_IDX_W+1:2]),
        .i_upd_taken (bus.upd_taken)
    );

    assign w_bxx_taken = w_rd_cnt[1];
`else
    assign w_bxx_taken = bus.dec_b_imm[ADDR_W-1];
`endif

    // Index bits, address tails and the regfile index are consumed elsewhere
    assign w_unused = ^{bus.if_pc, bus.upd_pc, bus.upd_vld, bus.upd_taken, bus.dec_rs_idx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.if_vld && bus.dec_bjp && w_is_jreg && bus.jr_rs_busy) begin
                        w_next = WAIT_RS;
                    end
                end
                WAIT_RS: begin
                    if (!bus.jr_rs_busy) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Flush and reset both silence the outputs in the same cycle
    always_comb begin
        w_prdt_vld   = 1'b0;
        w_prdt_taken = 1'b0;
        w_prdt_pc    = '0;
        w_bpu_wait   = 1'b0;
        if (rst_n && !bus.flush) begin
            if (r_state == WAIT_RS) begin
                if (bus.jr_rs_busy) begin
                    w_bpu_wait = 1'b1;
                end else begin
                    w_prdt_vld   = 1'b1;
                    w_prdt_taken = 1'b1;
                    w_prdt_pc    = bus.jr_rs_val;
                end
            end else if (bus.if_vld && bus.dec_bjp) begin
                if (w_is_jump) begin
                    w_prdt_vld   = 1'b1;
                    w_prdt_taken = 1'b1;
                    w_prdt_pc    = bus.dec_j_imm;
                end else if (w_is_jreg) begin
                    if (bus.jr_rs_busy) begin
                        w_bpu_wait = 1'b1;
                    end else begin
                        w_prdt_vld   = 1'b1;
                        w_prdt_taken = 1'b1;
                        w_prdt_pc    = bus.jr_rs_val;
                    end
                end else if (bus.dec_bxx) begin
                    w_prdt_vld   = 1'b1;
                    w_prdt_taken = w_bxx_taken;
                    w_prdt_pc    = w_b_target;
                end
            end
        end
    end

    assign bus.prdt_vld   = w_prdt_vld;
    assign bus.prdt_taken = w_prdt_taken;
    assign bus.prdt_pc    = w_prdt_pc;
    assign bus.bpu_wait   = w_bpu_wait;

endmodule

// File: doc/mips_if_bpu.md
Name: mips_if_bpu

Overview:
- Parametrised IF-stage branch prediction unit. Sits beside the IF mini-decoder and consumes its decoded BJP fields.
- Produces a taken/not-taken prediction and a next-fetch target for each fetched instruction.
- Stalls fetch (`bpu_wait`) while a JR/JALR base register is still in flight.
- Holds a table of 2-bit saturating counters (BHT), trained by the EX-stage branch resolution port.
- Delay-slot sequencing stays in the fetch sequencer, not here.

Parameters:
- ADDR_W, 32, PC/target width (matches `MIPS_ADDR_WIDTH`).
- RFIDX_W, 5, register index width.
- BHT_DEPTH, 64, number of BHT counters; power of two, at least 4.
- BHT_IDX_W, $clog2(BHT_DEPTH), BHT index width (derived, not overridable).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  synchronous active-low reset.
- `if_vld`  in  1  the instruction on the dec_* inputs is valid this cycle.
- `if_pc`  in  ADDR_W  PC of that instruction.
- `if_pc_incr`  in  ADDR_W  if_pc+4.
- `dec_bjp`, `dec_j`, `dec_jal`, `dec_jr`, `dec_jalr`, `dec_bxx`  in  1 each  mini-decoder BJP class flags.
- `dec_j_imm`  in  ADDR_W  absolute J/JAL target from the decoder.
- `dec_b_imm`  in  ADDR_W  sign-extended byte offset for Bxx.
- `dec_rs_idx`  in  RFIDX_W  JR/JALR base register index.
- `jr_rs_val`  in  ADDR_W  regfile read data for dec_rs_idx.
- `jr_rs_busy`  in  1  dec_rs_idx has a pending write in ID/EX/MEM.
- `upd_vld`  in  1  EX resolved a Bxx this cycle.
- `upd_pc`  in  ADDR_W  PC of the resolved Bxx.
- `upd_taken`  in  1  actual outcome of the resolved Bxx.
- `flush`  in  1  pipeline flush (mispredict/exception).
- `prdt_vld`  out  1  prediction below is valid.
- `prdt_taken`  out  1  predicted taken.
- `prdt_pc`  out  ADDR_W  predicted next-fetch target.
- `bpu_wait`  out  1  hold the IF stage.

Behaviour:
- Reset (`rst_n`=0 at a clk edge):
  - All BHT counters go to 2'b01 (weakly not-taken).
  - FSM goes to IDLE.
  - `prdt_vld`=0, `prdt_taken`=0, `prdt_pc`=0, `bpu_wait`=0.
  - Reset mid-stall drops the WAIT_RS state.
- BHT index is pc[BHT_IDX_W+1:2]. Bits [1:0] are ignored; aliasing is accepted.
- Predictions are combinational from the inputs and current state, zero latency. Outputs are 0 when `prdt_vld`=0.
- IDLE, if_vld=1:
  - J/JAL: `prdt_vld`=1, taken=1, target=`dec_j_imm`.
  - Bxx: `prdt_vld`=1, taken=BHT[idx(`if_pc`)][1], target=`if_pc_incr`+`dec_b_imm`, modulo 2^ADDR_W. The target is driven even when not taken.
  - JR/JALR with `jr_rs_busy`=0: `prdt_vld`=1, taken=1, target=`jr_rs_val`.
  - JR/JALR with `jr_rs_busy`=1: `bpu_wait`=1, `prdt_vld`=0; next state WAIT_RS.
  - Non-BJP: `prdt_vld`=0.
- WAIT_RS:
  - `bpu_wait`=1 while `jr_rs_busy`=1.
  - The IF holds `if_vld`, `if_pc` and `dec_*` stable throughout.
  - First cycle with busy=0: `bpu_wait`=0, `prdt_vld`=1, taken=1, target=`jr_rs_val`; next state IDLE.
- `flush`=1: next state IDLE, `bpu_wait`=0 and `prdt_vld`=0 in the same cycle. Flush beats all other events. BHT updates in the same cycle still apply.
- BHT update (`upd_vld`):
  - Saturating counter at idx(`upd_pc`): taken increments up to 2'b11, not-taken decrements down to 2'b00.
  - The write takes effect at the next clk edge.
- Read and update of the same index in the same cycle: the read sees the pre-update value (no bypass).
- if_vld=0: `prdt_vld`=0, `bpu_wait`=0 in IDLE; the FSM holds.

Optional Feature:
- Macro: `MIPS_BPU_BHT_EN`.
- Defined: dynamic BHT prediction as above.
- Undefined: no BHT storage is instantiated and `upd_*` is ignored. Bxx uses static BTFN: taken = `dec_b_imm`[ADDR_W-1] (backward taken). All other behaviour is identical.

Decomposition:
- Shared package/header `mips_defines`: FSM state encoding (IDLE=1'b0, WAIT_RS=1'b1), the BHT counter reset constant 2'b01, `MIPS_ADDR_WIDTH`, `MIPS_RFIDX_WIDTH`.
- One natural sub-module: `mips_if_bht` holds the counter array, read port and update port, parametrised by BHT_DEPTH. It is instantiated only under `MIPS_BPU_BHT_EN`.

Test Plan:
- Reset, then Bxx at pc=0x100, b_imm=0x40 -> `prdt_vld`=1, taken=0, `prdt_pc`=0x144.
- Two `upd_vld` taken updates at `upd_pc`=0x100, then the same Bxx -> taken=1, target 0x144. Three not-taken updates -> taken=0 and the counter saturates at 2'b00.
- JR with `jr_rs_busy`=1 for 3 cycles, `jr_rs_val`=0x2000 -> `bpu_wait`=1 for 3 cycles. On the 4th cycle `bpu_wait`=0, taken=1, `prdt_pc`=0x2000.
- JR stall with `flush`=1 on the 2nd wait cycle -> `bpu_wait`=0 and `prdt_vld`=0 that cycle; the FSM is in IDLE on the next cycle.
- Same-cycle read and update of idx 5 (pc=0x14, counter 01, upd taken) -> read gives taken=0. The next cycle gives taken=1.
- Without `MIPS_BPU_BHT_EN`: b_imm=0xFFFFFFF0 -> taken=1. b_imm=0x10 -> taken=0 regardless of `upd_*`.
